// File: rtl/mole_score_evaluator.sv
`default_nettype none
// ============================================================================
// Module      : mole_score_evaluator
// Description : Whack-a-mole round controller: arms a mole, judges the player
//               guess or timeout, holds the result, keeps a 4-digit BCD score.
//               Optional macro SCORE_PENALTY_EN: wrong/timeout decrements score.
// Revision    : 1.0 - initial release
// ============================================================================
module mole_score_evaluator #(
    parameter int RESPONSE_TIMEOUT = 100,
    parameter int COOLDOWN_CYCLES  = 100
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mole_valid,
    input  logic [2:0]  i_mole_position,
    input  logic        i_guess_valid,
    input  logic [2:0]  i_user_guess,
    output logic        o_ready,
    output logic [2:0]  o_mole_position,
    output logic [2:0]  o_user_guess,
    output logic        o_user_right,
    output logic        o_user_wrong,
    output logic [15:0] o_score
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam logic [27:0] c_TIMEOUT_LAST  = 28'(RESPONSE_TIMEOUT - 1);
    localparam logic [27:0] c_COOLDOWN_LAST = 28'(COOLDOWN_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [27:0] r_cnt, w_cnt_nxt;
    logic [2:0]  r_mole, w_mole_nxt;
    logic [2:0]  r_guess, w_guess_nxt;
    logic        r_right, w_right_nxt;
    logic        r_wrong, w_wrong_nxt;
    logic [15:0] r_score, w_score_nxt;
    logic        w_mole_onehot;

    // Saturating BCD increment, per-digit carry.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int d = 0; d < 4; d++) begin
                if (carry) begin
                    if (r[d*4 +: 4] == 4'd9) begin
                        r[d*4 +: 4] = 4'd0;
                    end else begin
                        r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

`ifdef SCORE_PENALTY_EN
    // Flooring BCD decrement, per-digit borrow.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        if (v != 16'h0000) begin
            for (int d = 0; d < 4; d++) begin
                if (borrow) begin
                    if (r[d*4 +: 4] == 4'd0) begin
                        r[d*4 +: 4] = 4'd9;
                    end else begin
                        r[d*4 +: 4] = r[d*4 +: 4] - 4'd1;
                        borrow      = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction
`endif

    assign w_mole_onehot = (i_mole_position == 3'b001) ||
                           (i_mole_position == 3'b010) ||
                           (i_mole_position == 3'b100);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mole  <= '0;
            r_guess <= '0;
            r_right <= 1'b0;
            r_wrong <= 1'b0;
            r_score <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mole  <= w_mole_nxt;
            r_guess <= w_guess_nxt;
            r_right <= w_right_nxt;
            r_wrong <= w_wrong_nxt;
            r_score <= w_score_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 28'd1;
        w_mole_nxt  = r_mole;
        w_guess_nxt = r_guess;
        w_right_nxt = 1'b0;
        w_wrong_nxt = 1'b0;
        w_score_nxt = r_score;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (i_mole_valid && w_mole_onehot) begin
                    w_state_nxt = ST_ARMED;
                    w_mole_nxt  = i_mole_position;
                end
            end
            ST_ARMED: begin
                // A guess in the last allowed cycle takes priority over the timeout.
                if (i_guess_valid && (i_user_guess != 3'b000)) begin
                    w_state_nxt = ST_SHOW;
                    w_cnt_nxt   = '0;
                    w_guess_nxt = i_user_guess;
                    if (i_user_guess == r_mole) begin
                        w_right_nxt = 1'b1;
                        w_score_nxt = bcd_inc(r_score);
                    end else begin
                        w_wrong_nxt = 1'b1;
`ifdef SCORE_PENALTY_EN
                        w_score_nxt = bcd_dec(r_score);
`endif
                    end
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    w_state_nxt = ST_SHOW;
                    w_cnt_nxt   = '0;
                    w_guess_nxt = 3'b000;
                    w_wrong_nxt = 1'b1;
`ifdef SCORE_PENALTY_EN
                    w_score_nxt = bcd_dec(r_score);
`endif
                end
            end
            ST_SHOW: begin
                if (r_cnt == c_COOLDOWN_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_mole_nxt  = 3'b000;
                    w_guess_nxt = 3'b000;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_mole_nxt  = 3'b000;
                w_guess_nxt = 3'b000;
            end
        endcase
    end

    assign o_ready         = (r_state == ST_IDLE);
    assign o_mole_position = r_mole;
    assign o_user_guess    = r_guess;
    assign o_user_right    = r_right;
    assign o_user_wrong    = r_wrong;
    assign o_score         = r_score;

endmodule
`default_nettype wire

// File: doc/mole_score_evaluator.md
# mole_score_evaluator

Round controller and scorer for the whack-a-mole game. Accepts a mole position from the mole generator, waits a bounded time for a debounced player guess, and judges it. Emits the one-cycle right/wrong pulses, latched guess and active mole position consumed by the LED display block. Keeps a 4-digit BCD score for the seven-segment driver.

## Interface
- `RESPONSE_TIMEOUT`, default 100 (1e8 on hardware): cycles the player has to guess once a mole is armed; range 2..2^28-1.
- `COOLDOWN_CYCLES`, default 100 (1e8 on hardware): cycles the result is held before the next mole is requested; matches the LED animation length; range 1..2^28-1.
- `i_clk` input 1: system clock; all logic on its rising edge.
- `i_rst` input 1: asynchronous, active-high reset.
- `i_mole_valid` input 1: one-cycle strobe; `i_mole_position` carries a new mole.
- `i_mole_position` input 3: mole hole, one-hot over 3 holes.
- `i_guess_valid` input 1: one-cycle strobe from the debounced buttons.
- `i_user_guess` input 3: buttons pressed, one-hot expected.
- `o_ready` output 1: high in IDLE; requests the next mole.
- `o_mole_position` output 3: armed mole, 3'b000 when none.
- `o_user_guess` output 3: last judged guess, 3'b000 on a miss.
- `o_user_right` output 1: one-cycle pulse, correct guess.
- `o_user_wrong` output 1: one-cycle pulse, wrong guess or timeout.
- `o_score` output 16: 4 BCD digits; [15:12] is thousands.

## Operation
- States:
  - IDLE: wait for `i_mole_valid`.
  - ARMED: wait for a guess or the timeout.
  - SHOW: cooldown.
- IDLE to ARMED:
  - Taken on `i_mole_valid` with exactly one bit set in `i_mole_position`; that position is latched into `o_mole_position`.
  - A strobe with zero or more than one bit set is ignored; the block stays in IDLE.
- ARMED, `i_guess_valid` with nonzero `i_user_guess`:
  - Latch the guess into `o_user_guess`.
  - If it equals `o_mole_position`: pulse `o_user_right` and increment the score.
  - Otherwise, including any multi-hot guess: pulse `o_user_wrong`.
  - Then go to SHOW.
- ARMED, guess equal to 3'b000: ignored.
- ARMED, timeout: `o_user_wrong` pulses, `o_user_guess` is set to 3'b000, then go to SHOW.
- SHOW:
  - `o_mole_position` and `o_user_guess` are held.
  - After `COOLDOWN_CYCLES` cycles, clear both to 3'b000 and go to IDLE.
- Input strobes outside their state are dropped:
  - guesses in IDLE or SHOW;
  - moles in ARMED or SHOW.
- Score: BCD increment with per-digit carry; saturates at 9999 (stays 9999).
- Reset values: state IDLE, `o_ready`=1, `o_mole_position`=0, `o_user_guess`=0, `o_user_right`=0, `o_user_wrong`=0, `o_score`=16'h0000, counters 0.
- Reset asserted mid-round aborts immediately. No pulse is issued.

## Timing
- `o_ready` is decoded from state and is 1 from the first cycle of IDLE.
- Mole strobe sampled at edge N:
  - ARMED, `o_ready`=0 and `o_mole_position` valid from N+1.
  - Timeout counter = 0 at N+1.
- Guess accepted in any ARMED cycle with counter 0..`RESPONSE_TIMEOUT`-1:
  - Guess sampled at edge M: pulse, `o_user_guess` and `o_score` all update at M+1; SHOW from M+1.
- No guess by counter = `RESPONSE_TIMEOUT`-1: the miss pulse is asserted the following cycle.
- A guess in that final cycle wins over the timeout.
- SHOW lasts exactly `COOLDOWN_CYCLES` cycles; IDLE follows.
- `o_user_right` and `o_user_wrong` are never high together and are never high for more than 1 cycle.
- Counters are 28 bits and clear on every state entry.

## Configuration
- `SCORE_PENALTY_EN` defined:
  - A wrong guess or timeout decrements the score in BCD, same cycle as `o_user_wrong`.
  - The score floors at 0000.
- Undefined: wrong and timeout leave the score unchanged.

## Test plan
Parameters: `RESPONSE_TIMEOUT`=20, `COOLDOWN_CYCLES`=10.
- Reset, then mole 3'b010, guess 3'b010 at ARMED cycle 5:
  - `o_user_right` high 1 cycle, score 0001.
  - `o_user_guess`=3'b010, `o_mole_position`=3'b010 for 10 cycles, then both 0 and `o_ready`=1.
- Mole 3'b100, guess 3'b001:
  - `o_user_wrong` 1 cycle, score unchanged.
  - With `SCORE_PENALTY_EN` from 0005: score 0004. From 0000: score 0000.
- Mole 3'b001, no guess: `o_user_wrong` exactly 21 cycles after the mole strobe, `o_user_guess`=0.
- Score preloaded via 9 rights to 0009, one more right: 0010. At 9999, another right: stays 9999.
- Invalid inputs are ignored:
  - Mole 3'b011 in IDLE leaves state unchanged.
  - Guess 3'b000 in ARMED is ignored, and the timeout still fires.
  - A guess during SHOW produces no pulse.
- `i_rst` pulsed while ARMED:
  - All outputs return to reset values asynchronously, with no pulse.
  - The next mole is accepted normally.
